// File: rtl/collision_pair_scheduler.sv
// Pair sweep scheduler: time-multiplexes one pairwise collision checker over all balls.
// Optional ONE_HIT_PER_BALL_EN: skip pairs whose balls already hit in this frame.
module collision_pair_scheduler #(
  parameter int NUM_BALLS = 4,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic [IDX_W-1:0]     idx_a,
  output logic [IDX_W-1:0]     idx_b,
  output logic                 chk_req,
  input  logic                 chk_ack,
  input  logic                 chk_hit,
  output logic                 wr_req,
  input  logic                 wr_ack,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_BALLS-1:0] hit_mask,
  output logic [4:0]           hit_count,
  output logic                 overrun,
  output logic                 timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(NUM_BALLS - 1);
  localparam logic [IDX_W-1:0] LAST_A  = IDX_W'(NUM_BALLS - 2);
  localparam logic [7:0]       TMO_END = 8'(TIMEOUT - 1);
  localparam logic [NUM_BALLS-1:0] ONE = NUM_BALLS'(1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_a_q, idx_a_d;
  logic [IDX_W-1:0]     idx_b_q, idx_b_d;
  logic                 chk_req_q, chk_req_d;
  logic                 wr_req_q, wr_req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_BALLS-1:0] mask_q, mask_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 tof_q, tof_d;
  logic [7:0]           tmo_q, tmo_d;

  logic [IDX_W-1:0]     nxt_a;
  logic [IDX_W-1:0]     nxt_b;
  logic                 nxt_last;
  logic                 nxt_skip;

  // Successor of the current pair in (i<j) lexicographic order.
  always_comb begin
    nxt_a    = idx_a_q;
    nxt_b    = idx_b_q;
    nxt_last = 1'b0;
    if (idx_b_q < LAST_B) begin
      nxt_b = idx_b_q + IDX_W'(1);
    end else if (idx_a_q < LAST_A) begin
      nxt_a = idx_a_q + IDX_W'(1);
      nxt_b = idx_a_q + IDX_W'(2);
    end else begin
      nxt_last = 1'b1;
    end
  end

`ifdef ONE_HIT_PER_BALL_EN
  assign nxt_skip = |(mask_q & ((ONE << nxt_a) | (ONE << nxt_b)));
`else
  assign nxt_skip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_a_d   = idx_a_q;
    idx_b_d   = idx_b_q;
    chk_req_d = chk_req_q;
    wr_req_d  = wr_req_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    tof_d     = tof_q;
    tmo_d     = tmo_q;

    if (frame_start && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          idx_a_d   = '0;
          idx_b_d   = IDX_W'(1);
          mask_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          chk_req_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (chk_ack) begin
          chk_req_d = 1'b0;
          if (chk_hit) begin
            mask_d   = mask_q | (ONE << idx_a_q) | (ONE << idx_b_q);
            cnt_d    = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
            wr_req_d = 1'b1;
            state_d  = S_WRITE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (tmo_q == TMO_END) begin
          chk_req_d = 1'b0;
          tof_d     = 1'b1;
          state_d   = S_NEXT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (nxt_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_a_d = nxt_a;
          idx_b_d = nxt_b;
          if (!nxt_skip) begin
            chk_req_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      chk_req_q <= 1'b0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mask_q    <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      tof_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_a_q   <= idx_a_d;
      idx_b_q   <= idx_b_d;
      chk_req_q <= chk_req_d;
      wr_req_q  <= wr_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      tof_q     <= tof_d;
      tmo_q     <= tmo_d;
    end
  end

  assign idx_a        = idx_a_q;
  assign idx_b        = idx_b_q;
  assign chk_req      = chk_req_q;
  assign wr_req       = wr_req_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign hit_mask     = mask_q;
  assign hit_count    = cnt_q;
  assign overrun      = ovr_q;
  assign timeout_flag = tof_q;

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Scoreboard bench for collision_pair_scheduler: expected pair order and
// write-backs are queued at frame start and popped as the DUT issues them.
module tb_collision_pair_scheduler;

  localparam int N    = 4;
  localparam int IW   = 3;
  localparam int TMO  = 15;
  localparam int NPR  = N * (N - 1) / 2;
  localparam int BUDG = 2000;

  logic          clk;
  logic          reset;
  logic          frame_start;
  logic [IW-1:0] idx_a;
  logic [IW-1:0] idx_b;
  logic          chk_req;
  logic          chk_ack;
  logic          chk_hit;
  logic          wr_req;
  logic          wr_ack;
  logic          busy;
  logic          done;
  logic [N-1:0]  hit_mask;
  logic [4:0]    hit_count;
  logic          overrun;
  logic          timeout_flag;

  collision_pair_scheduler #(
    .NUM_BALLS(N),
    .IDX_W(IW),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .idx_a(idx_a),
    .idx_b(idx_b),
    .chk_req(chk_req),
    .chk_ack(chk_ack),
    .chk_hit(chk_hit),
    .wr_req(wr_req),
    .wr_ack(wr_ack),
    .busy(busy),
    .done(done),
    .hit_mask(hit_mask),
    .hit_count(hit_count),
    .overrun(overrun),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nfail;

  int hit_mode;
  int hit_a, hit_b;
  int noack_a, noack_b;
  int wr_lat;
  int ovr_at;
  bit rst_in_write;

  int       exp_q[$];
  int       wexp_q[$];
  logic [N-1:0] exp_mask;
  int       exp_cnt;
  bit       exp_to;

  int done_cyc;
  int to_len;
  int wr_len;
  bit rst_hit;

  function automatic bit hit_fn(input int a, input int b);
    if (hit_mode == 2) return 1'b1;
    if (hit_mode == 1) return (a == hit_a) && (b == hit_b);
    return 1'b0;
  endfunction

  function automatic void build_model();
    exp_q.delete();
    wexp_q.delete();
    exp_mask = '0;
    exp_cnt  = 0;
    exp_to   = 1'b0;
    for (int a = 0; a < N - 1; a++) begin
      for (int b = a + 1; b < N; b++) begin
`ifdef ONE_HIT_PER_BALL_EN
        if (exp_mask[a] || exp_mask[b]) continue;
`endif
        exp_q.push_back(a * 16 + b);
        if (a == noack_a && b == noack_b) begin
          exp_to = 1'b1;
        end else if (hit_fn(a, b)) begin
          exp_mask[a] = 1'b1;
          exp_mask[b] = 1'b1;
          if (exp_cnt < 31) exp_cnt++;
          wexp_q.push_back(a * 16 + b);
        end
      end
    end
  endfunction

  task automatic cfg_default();
    hit_mode = 0; hit_a = -1; hit_b = -1;
    noack_a = -1; noack_b = -1;
    wr_lat = 1; ovr_at = -1; rst_in_write = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; frame_start = 1'b0;
    chk_ack = 1'b0; chk_hit = 1'b0; wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_sweep(output int n_done);
    int ca, wa, cyc, stop_at, cur, got, prv, pair;
    bit prev_any, stop;
    n_done = 0; ca = 0; wa = 0; cyc = 0; stop_at = -1; cur = -1;
    prev_any = 1'b0; prv = 0; stop = 1'b0;
    done_cyc = -1; to_len = -1; wr_len = -1; rst_hit = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    while (!stop) begin
      @(negedge clk);
      cyc++;
      frame_start = (cyc == ovr_at);
      chk_ack = 1'b0; chk_hit = 1'b0; wr_ack = 1'b0;
      pair = int'(idx_a) * 16 + int'(idx_b);
      nchk++;
      if (chk_req && wr_req) begin
        nfail++;
        $display("FAIL req_overlap cyc=%0d chk_req=%b wr_req=%b want not both", cyc, chk_req, wr_req);
      end
      if (prev_any && (chk_req || wr_req)) begin
        nchk++;
        if (pair !== prv) begin
          nfail++;
          $display("FAIL idx_stable cyc=%0d got %0h want %0h", cyc, pair, prv);
        end
      end
      if (cyc == 1) begin
        nchk++;
        if (busy !== 1'b1) begin
          nfail++;
          $display("FAIL busy_start got %b want 1", busy);
        end
      end
      if (chk_req) begin
        ca++;
        if (ca == 1) begin
          cur = pair;
          nchk++;
          if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL pair_order got %0h want none", pair);
          end else begin
            got = exp_q.pop_front();
            if (pair !== got) begin
              nfail++;
              $display("FAIL pair_order got %0h want %0h", pair, got);
            end
          end
        end
        if (ca == 2 && cur != noack_a * 16 + noack_b) begin
          chk_ack = 1'b1;
          chk_hit = hit_fn(int'(idx_a), int'(idx_b));
        end
      end else if (ca > 0) begin
        if (cur == noack_a * 16 + noack_b) to_len = ca;
        ca = 0;
      end
      if (wr_req) begin
        wa++;
        if (wa == 1) begin
          nchk++;
          if (wexp_q.size() == 0) begin
            nfail++;
            $display("FAIL wr_pair got %0h want none", pair);
          end else begin
            got = wexp_q.pop_front();
            if (pair !== got) begin
              nfail++;
              $display("FAIL wr_pair got %0h want %0h", pair, got);
            end
          end
        end
        if (rst_in_write && wa == 2) begin
          reset = 1'b1;
          rst_hit = 1'b1;
          stop = 1'b1;
        end else if (wa == wr_lat) begin
          wr_ack = 1'b1;
        end
      end else if (wa > 0) begin
        wr_len = wa;
        wa = 0;
      end
      if (done) begin
        n_done++;
        if (stop_at < 0) begin
          done_cyc = cyc;
          stop_at = cyc + 3;
        end
      end
      if (cyc == stop_at) stop = 1'b1;
      if (cyc >= BUDG && !stop) begin
        nchk++; nfail++;
        $display("FAIL sweep_budget got %0d cycles want done", cyc);
        stop = 1'b1;
      end
      prev_any = chk_req || wr_req;
      prv = pair;
    end
    chk_ack = 1'b0; chk_hit = 1'b0; wr_ack = 1'b0; frame_start = 1'b0;
  endtask

  task automatic check_end(input string nm, input int nd);
    nchk++;
    if (nd !== 1) begin
      nfail++;
      $display("FAIL %s done_count got %0d want 1", nm, nd);
    end
    nchk++;
    if (exp_q.size() != 0 || wexp_q.size() != 0) begin
      nfail++;
      $display("FAIL %s missing pairs=%0d writes=%0d want 0 0", nm, exp_q.size(), wexp_q.size());
    end
    nchk++;
    if (hit_mask !== exp_mask) begin
      nfail++;
      $display("FAIL %s hit_mask got %b want %b", nm, hit_mask, exp_mask);
    end
    nchk++;
    if (hit_count !== 5'(exp_cnt)) begin
      nfail++;
      $display("FAIL %s hit_count got %0d want %0d", nm, hit_count, exp_cnt);
    end
    nchk++;
    if (timeout_flag !== exp_to) begin
      nfail++;
      $display("FAIL %s timeout_flag got %b want %b", nm, timeout_flag, exp_to);
    end
    nchk++;
    if (overrun !== (ovr_at > 0)) begin
      nfail++;
      $display("FAIL %s overrun got %b want %b", nm, overrun, ovr_at > 0);
    end
    nchk++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s busy_end got %b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b1;
    chk_ack = 1'b1; chk_hit = 1'b1; wr_ack = 1'b1;
    repeat (3) @(negedge clk);
    nchk++;
    if ({idx_a, idx_b, chk_req, wr_req, busy, done, hit_mask,
         hit_count, overrun, timeout_flag} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs got a=%0d b=%0d req=%b wr=%b busy=%b mask=%b cnt=%0d want all 0",
               idx_a, idx_b, chk_req, wr_req, busy, hit_mask, hit_count);
    end
    reset = 1'b0; frame_start = 1'b0;
    chk_ack = 1'b0; chk_hit = 1'b0; wr_ack = 1'b0;
  endtask

  task automatic test_no_hit();
    int nd;
    cfg_default(); apply_reset(); build_model();
    run_sweep(nd);
    check_end("no_hit", nd);
    nchk++;
    if (done_cyc !== 3 * NPR + 1) begin
      nfail++;
      $display("FAIL no_hit done_cycle got %0d want %0d", done_cyc, 3 * NPR + 1);
    end
    nchk++;
    if (hit_mask !== 4'b0000) begin
      nfail++;
      $display("FAIL no_hit mask_zero got %b want 0000", hit_mask);
    end
  endtask

  task automatic test_hit_write();
    int nd;
    cfg_default(); apply_reset();
    hit_mode = 1; hit_a = 1; hit_b = 3; wr_lat = 4;
    build_model();
    run_sweep(nd);
    check_end("hit_write", nd);
    nchk++;
    if (wr_len !== 4) begin
      nfail++;
      $display("FAIL hit_write wr_len got %0d want 4", wr_len);
    end
    nchk++;
    if (hit_mask !== 4'b1010 || hit_count !== 5'd1) begin
      nfail++;
      $display("FAIL hit_write summary got %b/%0d want 1010/1", hit_mask, hit_count);
    end
  endtask

  task automatic test_timeout();
    int nd;
    cfg_default(); apply_reset();
    noack_a = 0; noack_b = 2;
    build_model();
    run_sweep(nd);
    check_end("timeout", nd);
    nchk++;
    if (to_len !== TMO + 1) begin
      nfail++;
      $display("FAIL timeout req_len got %0d want %0d", to_len, TMO + 1);
    end
  endtask

  task automatic test_overrun();
    int nd;
    cfg_default(); apply_reset();
    ovr_at = 7; hit_mode = 1; hit_a = 0; hit_b = 3;
    build_model();
    run_sweep(nd);
    check_end("overrun", nd);
  endtask

  task automatic test_reset_write();
    int nd;
    cfg_default(); apply_reset();
    hit_mode = 1; hit_a = 0; hit_b = 1; wr_lat = 1000; rst_in_write = 1'b1;
    build_model();
    run_sweep(nd);
    nchk++;
    if (!rst_hit) begin
      nfail++;
      $display("FAIL rst_write reached_write got 0 want 1");
    end
    @(negedge clk);
    reset = 1'b0;
    nchk++;
    if ({idx_a, idx_b, chk_req, wr_req, busy, done, hit_mask,
         hit_count, overrun, timeout_flag} !== '0) begin
      nfail++;
      $display("FAIL rst_write outputs got wr=%b busy=%b mask=%b cnt=%0d want all 0",
               wr_req, busy, hit_mask, hit_count);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nchk++;
      if (done !== 1'b0 || chk_req !== 1'b0 || busy !== 1'b0) begin
        nfail++;
        $display("FAIL rst_write idle got done=%b req=%b busy=%b want 0 0 0", done, chk_req, busy);
      end
    end
    cfg_default(); build_model();
    run_sweep(nd);
    check_end("rst_restart", nd);
  endtask

`ifdef ONE_HIT_PER_BALL_EN
  task automatic test_one_hit();
    int nd;
    cfg_default(); apply_reset();
    hit_mode = 2;
    build_model();
    run_sweep(nd);
    check_end("one_hit", nd);
    nchk++;
    if (hit_mask !== 4'b1111 || hit_count !== 5'd2) begin
      nfail++;
      $display("FAIL one_hit summary got %b/%0d want 1111/2", hit_mask, hit_count);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0; nfail = 0;
    cfg_default();
    test_reset();
    test_no_hit();
    test_hit_write();
    test_timeout();
    test_overrun();
    test_reset_write();
`ifdef ONE_HIT_PER_BALL_EN
    test_one_hit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/collision_pair_scheduler.md
Name: collision_pair_scheduler

Overview:
- Time-multiplexes one shared pairwise collision checker across NUM_BALLS balls.
- Once per frame, walks every unordered pair (i<j) and presents the pair indices to the checker. For each hit, issues a speed write-back request to the ball register file.
- Sits between the frame-timing logic (vsync-derived frame_start) and the checker/ball-state datapath. Reports per-frame hit summary and status flags.

Parameters:
- NUM_BALLS, 4, number of balls; legal range 2..8.
- IDX_W, 3, width of ball index outputs; must satisfy 2^IDX_W >= NUM_BALLS.
- TIMEOUT, 15, max cycles to wait for chk_ack before abandoning a pair; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- frame_start  input  1  single-cycle pulse; starts a new pair sweep
- idx_a  output  IDX_W  lower ball index of current pair
- idx_b  output  IDX_W  higher ball index of current pair
- chk_req  output  1  request to checker; held high until chk_ack or timeout
- chk_ack  input  1  checker result valid, one-cycle pulse
- chk_hit  input  1  collision result, sampled only when chk_ack=1
- wr_req  output  1  write-back request for new speeds of idx_a/idx_b; held until wr_ack
- wr_ack  input  1  ball register file accepted write
- busy  output  1  high from sweep start until DONE
- done  output  1  one-cycle pulse when sweep completes
- hit_mask  output  NUM_BALLS  bit k set if ball k hit anything this frame
- hit_count  output  5  number of hit pairs this frame, saturating at 31
- overrun  output  1  sticky: frame_start received while busy
- timeout_flag  output  1  sticky: a checker request timed out

Behaviour:
- Reset: synchronous active-high. Reset wins over every other input in the same cycle.
  - All outputs go to 0: idx_a, idx_b, chk_req, wr_req, busy, done, hit_mask, hit_count, overrun, timeout_flag.
  - State goes to IDLE; the pair and timeout counters clear.
  - Reset mid-sweep abandons the sweep immediately with no done pulse. An outstanding wr_req drops.
- States: IDLE, ISSUE, WAIT, WRITE, NEXT, DONE.
- IDLE:
  - On frame_start: idx_a=0, idx_b=1; clear hit_mask and hit_count; busy=1; go to ISSUE.
  - The ISSUE state is entered the cycle after the frame_start pulse.
- ISSUE: assert chk_req, clear the timeout counter, go to WAIT. chk_req is first high 1 cycle after frame_start.
- WAIT: chk_req stays high. The timeout counter increments each cycle.
  - chk_ack=1 and chk_hit=1: drop chk_req; set hit_mask[idx_a] and hit_mask[idx_b]; increment hit_count with saturation at 31; go to WRITE.
  - chk_ack=1 and chk_hit=0: drop chk_req, go to NEXT.
  - Counter reaches TIMEOUT with no ack: drop chk_req, set timeout_flag, treat the pair as no-hit, go to NEXT.
  - chk_ack in the same cycle the counter reaches TIMEOUT: the ack wins.
- WRITE:
  - wr_req is high with idx_a/idx_b held stable until the cycle wr_ack=1.
  - That cycle wr_req drops and the state goes to NEXT. No timeout in WRITE.
- NEXT:
  - If idx_b < NUM_BALLS-1: idx_b += 1.
  - Else if idx_a < NUM_BALLS-2: idx_a += 1, idx_b = idx_a+1 (new value).
  - Else go to DONE. Otherwise go to ISSUE.
- Pair order for NUM_BALLS=4: (0,1) (0,2) (0,3) (1,2) (1,3) (2,3). That is NUM_BALLS*(NUM_BALLS-1)/2 pairs.
- DONE:
  - done=1 for exactly one cycle, busy=0, return to IDLE.
  - hit_mask and hit_count hold until the next sweep start.
- frame_start while busy (any state but IDLE):
  - Ignored and sets overrun. The sweep continues unaffected.
  - A frame_start in the DONE cycle is also ignored and sets overrun.
- chk_ack outside WAIT and wr_ack outside WRITE are ignored.
- Handshake invariants: chk_req and wr_req are never high together, and idx_a/idx_b never change while either is high.
- Minimum sweep with no hits, ack on the first WAIT cycle: 3 cycles per pair plus 1 for DONE.

Optional Feature:
- Macro ONE_HIT_PER_BALL_EN.
- Defined:
  - In NEXT, after advancing the indices, if hit_mask[idx_a] or hit_mask[idx_b] is already set, skip that pair without issuing chk_req.
  - NEXT keeps advancing, one pair per cycle, until it reaches a pair with both balls unhit or the sweep ends.
  - Skipped pairs do not affect hit_count.
- Not defined: every pair is checked every frame.

Test Plan:
- NUM_BALLS=4, frame_start, checker acks every request 1 cycle after chk_req with hit=0:
  - Six requests in order (0,1)(0,2)(0,3)(1,2)(1,3)(2,3).
  - done pulses once; hit_mask=0000, hit_count=0.
- Same stimulus, but hit=1 only on pair (1,3) and wr_ack delayed 4 cycles:
  - wr_req held 4 cycles with idx_a=1, idx_b=3.
  - End of sweep: hit_mask=1010, hit_count=1.
- Checker never acks pair (0,2) with TIMEOUT=15:
  - chk_req drops after 15 cycles and timeout_flag=1.
  - The sweep continues to (0,3) and done still pulses.
- frame_start pulsed again mid-sweep: overrun=1, pair sequence unchanged, exactly one done.
- reset asserted during WRITE: next cycle all outputs 0 and state IDLE, no done. A following frame_start restarts at (0,1).
- ONE_HIT_PER_BALL_EN defined, hit on (0,1) and all other acks hit=1:
  - Issued pairs are (0,1) and (2,3) only.
  - hit_mask=1111, hit_count=2.
